// File: rtl/display_arbiter_if.sv
// Bundle between the display requesters and display_arbiter.
// master = requester side (drives src_*), slave = arbiter side (drives grant/bcd_*).
interface display_arbiter_if #(
  parameter int NUM_SRC = 3
);
  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]    src_req;
  logic [NUM_SRC-1:0]    src_wr;
  logic [24*NUM_SRC-1:0] src_bcd;
  logic [NUM_SRC-1:0]    grant;
  logic [IDW-1:0]        owner_id;
  logic [23:0]           bcd_out;
  logic                  bcd_valid;

  modport master (
    output src_req, src_wr, src_bcd,
    input  grant, owner_id, bcd_out, bcd_valid
  );

  modport slave (
    input  src_req, src_wr, src_bcd,
    output grant, owner_id, bcd_out, bcd_valid
  );
endinterface

// File: rtl/display_arbiter.sv
// Fixed-priority owner of the shared 6-digit BCD display (index 0 wins).
// Optional idle auto-blank is compiled in when DISP_TIMEOUT_EN is defined.
module display_arbiter #(
  parameter int NUM_SRC        = 3,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input logic              clk,
  input logic              rst,
  display_arbiter_if.slave bus
);
  localparam int          IDW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [23:0] BLANK = 24'hAAAAAA;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    OWNED  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [23:0]        bcd_q, bcd_d;
  logic               valid_q, valid_d;

  logic [23:0]        pkt [NUM_SRC];
  logic               req_any;
  logic [IDW-1:0]     req_top;
  logic               owner_lost;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign pkt[gi] = bus.src_bcd[24*gi +: 24];
  end

  always_comb begin
    req_top = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.src_req[i]) req_top = IDW'(i);
    end
  end

  assign req_any    = |bus.src_req;
  // Owner keeps the display only while it is still the top requester.
  assign owner_lost = !req_any || (req_top != owner_q);

`ifdef DISP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
`else
  // Keeps the timeout parameter referenced when the feature is compiled out.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
`ifdef DISP_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = SWITCH;
          bcd_d   = BLANK;
          valid_d = 1'b1;
        end
      end
      SWITCH: begin
        if (req_any) begin
          state_d = OWNED;
          owner_d = req_top;
          grant_d = NUM_SRC'(1) << req_top;
          bcd_d   = pkt[req_top];
          valid_d = 1'b1;
`ifdef DISP_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      OWNED: begin
        if (owner_lost) begin
          // A write in the same cycle as release/preemption is dropped.
          state_d = SWITCH;
          owner_d = '0;
          grant_d = '0;
          bcd_d   = BLANK;
          valid_d = 1'b1;
        end else if (bus.src_wr[owner_q]) begin
          bcd_d   = pkt[owner_q];
          valid_d = 1'b1;
`ifdef DISP_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
        end
`ifdef DISP_TIMEOUT_EN
        else if (idle_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
          // Counter saturates at the limit so the blank strobe fires once.
          idle_cnt_d = idle_cnt_q + 1'b1;
          if (idle_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            bcd_d   = BLANK;
            valid_d = 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      grant_q <= '0;
      bcd_q   <= BLANK;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.owner_id  = owner_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.bcd_valid = valid_q;
endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed scenarios plus a randomized
// run against an ownership-level reference model.
module tb_display_arbiter;
  localparam int          N     = 3;
  localparam int          TO    = 8;
  localparam logic [23:0] BLANK = 24'hAAAAAA;
`ifdef DISP_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_arbiter_if #(.NUM_SRC(N)) bus ();
  display_arbiter #(.NUM_SRC(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the display, whether a hand-over is in progress,
  // what the display shows and whether it changed this cycle.
  int          m_owner;
  bit          m_switching;
  logic [23:0] m_disp;
  bit          m_strobe;
  int          m_quiet;

  function automatic int top_req(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [23:0] pkt_of(input int i);
    return bus.src_bcd[24*i +: 24];
  endfunction

  function automatic logic [N-1:0] exp_grant();
    return (m_owner < 0) ? '0 : (N'(1) << m_owner);
  endfunction

  function automatic logic [1:0] exp_id();
    return (m_owner < 0) ? 2'd0 : 2'(m_owner);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_switching = 0; m_disp = BLANK; m_strobe = 0; m_quiet = 0;
  endtask

  task automatic model_step();
    int hp;
    hp = top_req(bus.src_req);
    m_strobe = 0;
    if (m_switching) begin
      m_switching = 0;
      if (hp >= 0) begin
        m_owner = hp; m_disp = pkt_of(hp); m_strobe = 1; m_quiet = 0;
      end
    end else if (m_owner < 0) begin
      if (hp >= 0) begin m_switching = 1; m_disp = BLANK; m_strobe = 1; end
    end else if (hp != m_owner) begin
      m_owner = -1; m_switching = 1; m_disp = BLANK; m_strobe = 1;
    end else if (bus.src_wr[m_owner]) begin
      m_disp = pkt_of(m_owner); m_strobe = 1; m_quiet = 0;
    end else if (TIMEOUT_ON && m_quiet < TO) begin
      m_quiet++;
      if (m_quiet == TO) begin m_disp = BLANK; m_strobe = 1; end
    end
  endtask

  // One clock: advance model on current inputs, return at the falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_pkt(input int i, input logic [23:0] v);
    bus.src_bcd[24*i +: 24] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.src_req = '0; bus.src_wr = '0; bus.src_bcd = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", bus.grant); end
    checks++; if (bus.bcd_out !== 24'hAAAAAA) begin errors++; $display("FAIL reset_bcd: got %h want aaaaaa", bus.bcd_out); end
    checks++; if (bus.bcd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.bcd_valid); end
    checks++; if (bus.owner_id !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", bus.owner_id); end
    rst = 1'b0;
    tick();
    checks++; if ({bus.grant, bus.bcd_out, bus.bcd_valid} !== {3'b000, 24'hAAAAAA, 1'b0})
      begin errors++; $display("FAIL reset_release: got %b/%h/%b want 000/aaaaaa/0", bus.grant, bus.bcd_out, bus.bcd_valid); end
  endtask

  task automatic test_owner_write();
    bus.src_req = 3'b100; set_pkt(2, 24'h01AAA1);
    tick();
    checks++; if ({bus.grant, bus.bcd_out, bus.bcd_valid} !== {3'b000, 24'hAAAAAA, 1'b1})
      begin errors++; $display("FAIL ow_switch: got %b/%h/%b want 000/aaaaaa/1", bus.grant, bus.bcd_out, bus.bcd_valid); end
    tick();
    checks++; if ({bus.grant, bus.owner_id, bus.bcd_out, bus.bcd_valid} !== {3'b100, 2'd2, 24'h01AAA1, 1'b1})
      begin errors++; $display("FAIL ow_grant: got %b/%0d/%h/%b want 100/2/01aaa1/1", bus.grant, bus.owner_id, bus.bcd_out, bus.bcd_valid); end
    tick();
    checks++; if (bus.bcd_valid !== 1'b0) begin errors++; $display("FAIL ow_strobe_len: got %b want 0", bus.bcd_valid); end
    bus.src_wr = 3'b100; set_pkt(2, 24'h01AAA0);
    tick();
    bus.src_wr = '0;
    checks++; if ({bus.bcd_out, bus.bcd_valid} !== {24'h01AAA0, 1'b1})
      begin errors++; $display("FAIL ow_write: got %h/%b want 01aaa0/1", bus.bcd_out, bus.bcd_valid); end
  endtask

  task automatic test_preempt();
    set_pkt(0, 24'h0A1234); set_pkt(2, 24'h123456);
    bus.src_req = 3'b101; bus.src_wr = 3'b100;
    tick();
    bus.src_wr = '0;
    checks++; if ({bus.grant, bus.bcd_out, bus.bcd_valid} !== {3'b000, 24'hAAAAAA, 1'b1})
      begin errors++; $display("FAIL pre_blank: got %b/%h/%b want 000/aaaaaa/1", bus.grant, bus.bcd_out, bus.bcd_valid); end
    tick();
    checks++; if ({bus.grant, bus.owner_id, bus.bcd_out} !== {3'b001, 2'd0, 24'h0A1234})
      begin errors++; $display("FAIL pre_owner: got %b/%0d/%h want 001/0/0a1234", bus.grant, bus.owner_id, bus.bcd_out); end
  endtask

  task automatic test_lower_waits();
    bus.src_req = 3'b011; set_pkt(1, 24'h555555);
    repeat (3) begin
      tick();
      checks++; if ({bus.grant, bus.bcd_valid} !== {3'b001, 1'b0})
        begin errors++; $display("FAIL low_wait: got %b/%b want 001/0", bus.grant, bus.bcd_valid); end
    end
    bus.src_req = 3'b010;
    tick();
    checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL low_switch: got %b want 000", bus.grant); end
    tick();
    checks++; if ({bus.grant, bus.owner_id, bus.bcd_out} !== {3'b010, 2'd1, 24'h555555})
      begin errors++; $display("FAIL low_owner: got %b/%0d/%h want 010/1/555555", bus.grant, bus.owner_id, bus.bcd_out); end
  endtask

  task automatic test_write_release();
    set_pkt(1, 24'h987654); bus.src_wr = 3'b010; bus.src_req = 3'b000;
    tick();
    bus.src_wr = '0;
    checks++; if ({bus.grant, bus.bcd_out, bus.bcd_valid} !== {3'b000, 24'hAAAAAA, 1'b1})
      begin errors++; $display("FAIL wr_rel_drop: got %b/%h/%b want 000/aaaaaa/1", bus.grant, bus.bcd_out, bus.bcd_valid); end
    tick();
    checks++; if ({bus.grant, bus.bcd_out, bus.bcd_valid} !== {3'b000, 24'hAAAAAA, 1'b0})
      begin errors++; $display("FAIL wr_rel_idle: got %b/%h/%b want 000/aaaaaa/0", bus.grant, bus.bcd_out, bus.bcd_valid); end
  endtask

  task automatic test_switch_drop();
    bus.src_req = 3'b010;
    tick();
    bus.src_req = 3'b000;
    tick();
    checks++; if ({bus.grant, bus.bcd_out, bus.bcd_valid} !== {3'b000, 24'hAAAAAA, 1'b0})
      begin errors++; $display("FAIL sw_drop: got %b/%h/%b want 000/aaaaaa/0", bus.grant, bus.bcd_out, bus.bcd_valid); end
    tick();
    checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL sw_drop_idle: got %b want 000", bus.grant); end
  endtask

  task automatic test_timeout();
    int pulses;
    bus.src_req = 3'b100; set_pkt(2, 24'h314159);
    tick(); tick();
    pulses = 0;
    repeat (3 * TO / 2) begin
      tick();
      if (bus.bcd_valid === 1'b1) pulses++;
    end
`ifdef DISP_TIMEOUT_EN
    checks++; if ({pulses, bus.bcd_out, bus.grant} !== {32'd1, 24'hAAAAAA, 3'b100})
      begin errors++; $display("FAIL to_blank: got pulses %0d %h %b want 1 aaaaaa 100", pulses, bus.bcd_out, bus.grant); end
`else
    checks++; if ({pulses, bus.bcd_out, bus.grant} !== {32'd0, 24'h314159, 3'b100})
      begin errors++; $display("FAIL to_none: got pulses %0d %h %b want 0 314159 100", pulses, bus.bcd_out, bus.grant); end
`endif
    bus.src_wr = 3'b100; set_pkt(2, 24'h271828);
    tick();
    bus.src_wr = '0;
    checks++; if ({bus.bcd_out, bus.bcd_valid} !== {24'h271828, 1'b1})
      begin errors++; $display("FAIL to_restore: got %h/%b want 271828/1", bus.bcd_out, bus.bcd_valid); end
  endtask

  task automatic test_reset_mid_op();
    bus.src_req = 3'b001; set_pkt(0, 24'h424242);
    tick(); tick();
    checks++; if (bus.bcd_out !== 24'h424242) begin errors++; $display("FAIL mid_pre: got %h want 424242", bus.bcd_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.grant, bus.bcd_out, bus.bcd_valid} !== {3'b000, 24'hAAAAAA, 1'b0})
      begin errors++; $display("FAIL mid_async: got %b/%h/%b want 000/aaaaaa/0", bus.grant, bus.bcd_out, bus.bcd_valid); end
    model_reset();
    @(negedge clk);
    bus.src_req = '0;
    rst = 1'b0;
    tick();
    checks++; if (bus.bcd_valid !== 1'b0) begin errors++; $display("FAIL mid_no_strobe: got %b want 0", bus.bcd_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus.src_req = N'($urandom_range(0, 7));
      bus.src_wr  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      bus.src_bcd = {$urandom, $urandom, $urandom};
      tick();
      checks++; if ({bus.grant, bus.owner_id} !== {exp_grant(), exp_id()})
        begin errors++; $display("FAIL rnd_owner cycle %0d: got %b/%0d want %b/%0d", c, bus.grant, bus.owner_id, exp_grant(), exp_id()); end
      checks++; if ({bus.bcd_out, bus.bcd_valid} !== {m_disp, m_strobe})
        begin errors++; $display("FAIL rnd_display cycle %0d: got %h/%b want %h/%b", c, bus.bcd_out, bus.bcd_valid, m_disp, m_strobe); end
    end
    bus.src_req = '0; bus.src_wr = '0;
  endtask

  initial begin
    test_reset();
    test_owner_write();
    test_preempt();
    test_lower_waits();
    test_write_release();
    test_switch_drop();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
